// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request, issue handshake to decode
// and redirect input from execute.
interface instruction_fetch_unit_if #(
   parameter int ADDR_WIDTH  = 24,
   parameter int INSTR_WIDTH = 24
);
   logic                   ImemReq;
   logic [ADDR_WIDTH-1:0]  ImemAddr;
   logic                   ImemAck;
   logic [INSTR_WIDTH-1:0] ImemData;
   logic                   InstrValid;
   logic                   InstrReady;
   logic [INSTR_WIDTH-1:0] Instr;
   logic [ADDR_WIDTH-1:0]  InstrPC;
   logic [3:0]             OPCODE;
   logic                   InstrIllegal;
   logic                   Redirect;
   logic [ADDR_WIDTH-1:0]  RedirectPC;
   logic                   Halted;

   modport master (
      output ImemReq,
      output ImemAddr,
      input  ImemAck,
      input  ImemData,
      output InstrValid,
      input  InstrReady,
      output Instr,
      output InstrPC,
      output OPCODE,
      output InstrIllegal,
      input  Redirect,
      input  RedirectPC,
      output Halted
   );

   modport slave (
      input  ImemReq,
      input  ImemAddr,
      output ImemAck,
      output ImemData,
      input  InstrValid,
      output InstrReady,
      input  Instr,
      input  InstrPC,
      input  OPCODE,
      input  InstrIllegal,
      output Redirect,
      output RedirectPC,
      input  Halted
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: PC, req/ack memory fetch, valid/ready issue,
// redirect handling and HALT stop.
module instruction_fetch_unit #(
   parameter int                    ADDR_WIDTH  = 24,
   parameter int                    INSTR_WIDTH = 24,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                      Clock,
   input  logic                      Reset,
   instruction_fetch_unit_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_DRAIN,
      S_HALT
   } state_e;

   localparam logic [3:0] OP_HALT = 4'hF;

   state_e                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
   logic [ADDR_WIDTH-1:0]  pend_q, pend_d;
   logic [ADDR_WIDTH-1:0]  ipc_q, ipc_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [3:0]             opcode;
   logic                   legal;

   assign opcode = instr_q[INSTR_WIDTH-1 -: 4];

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         pend_q  <= '0;
         ipc_q   <= '0;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
         ipc_q   <= ipc_d;
         instr_q <= instr_d;
      end
   end

   // pc_q is the live request address in both FETCH and DRAIN,
   // so it must only move when the request completes.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pend_d  = pend_q;
      ipc_d   = ipc_q;
      instr_d = instr_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.Redirect) pc_d = bus.RedirectPC;
            state_d = S_FETCH;
         end
         S_FETCH: begin
            if (bus.Redirect) begin
               if (bus.ImemAck) begin
                  pc_d = bus.RedirectPC;
               end else begin
                  pend_d  = bus.RedirectPC;
                  state_d = S_DRAIN;
               end
            end else if (bus.ImemAck) begin
               instr_d = bus.ImemData;
               ipc_d   = pc_q;
               pc_d    = pc_q + 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_DRAIN: begin
            if (bus.ImemAck) begin
               pc_d    = bus.Redirect ? bus.RedirectPC : pend_q;
               state_d = S_FETCH;
            end else if (bus.Redirect) begin
               pend_d = bus.RedirectPC;
            end
         end
         S_ISSUE: begin
            if (bus.Redirect) begin
               pc_d    = bus.RedirectPC;
               state_d = S_FETCH;
            end else if (bus.InstrReady) begin
               state_d = (opcode == OP_HALT) ? S_HALT : S_FETCH;
            end
         end
         S_HALT: begin
            if (bus.Redirect) begin
               pc_d    = bus.RedirectPC;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      legal = 1'b0;
      unique case (opcode)
         4'h1, 4'h2, 4'h3,
         4'h4, 4'h6, 4'hF: legal = 1'b1;
         default:          legal = 1'b0;
      endcase
   end

   assign bus.ImemReq      = (state_q == S_FETCH) || (state_q == S_DRAIN);
   assign bus.ImemAddr     = pc_q;
   assign bus.InstrValid   = (state_q == S_ISSUE);
   assign bus.Instr        = instr_q;
   assign bus.InstrPC      = ipc_q;
   assign bus.OPCODE       = opcode;
   assign bus.InstrIllegal = bus.InstrValid & ~legal;
   assign bus.Halted       = (state_q == S_HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a transaction-level
// model, plus a directed wrap/reset check on a RESET_PC=0xFFFFFF instance.
module tb_instruction_fetch_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst2 = 1'b1;
   always #5 clk = ~clk;

   instruction_fetch_unit_if bus ();
   instruction_fetch_unit_if bus2 ();

   instruction_fetch_unit dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus)
   );

   instruction_fetch_unit #(.RESET_PC(24'hFFFFFF)) dut2 (
      .Clock (clk),
      .Reset (rst2),
      .bus   (bus2)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] memf(logic [23:0] a);
      logic [23:0] h;
      h = (a ^ (a >> 7)) * 24'h2F1A3 + 24'h1D37;
      return h ^ (h >> 11);
   endfunction

   function automatic bit is_illegal(logic [3:0] op);
      return !(op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'hF});
   endfunction

   // model: what the architectural front end should be doing
   bit          m_started, m_valid, m_halted, m_kill;
   logic [23:0] m_pc, m_ipc, m_word, m_tgt;

   task automatic model_reset();
      m_started = 0;
      m_valid   = 0;
      m_halted  = 0;
      m_kill    = 0;
      m_pc      = 24'h0;
      m_ipc     = 24'h0;
      m_word    = 24'h0;
      m_tgt     = 24'h0;
   endtask

   task automatic check_main();
      bit fetching;
      fetching = m_started && !m_valid && !m_halted;
      chk("req", bus.ImemReq, fetching);
      if (fetching) chk("addr", bus.ImemAddr, m_pc);
      chk("valid", bus.InstrValid, m_valid);
      chk("halted", bus.Halted, m_halted);
      chk("instr", bus.Instr, m_word);
      chk("ipc", bus.InstrPC, m_ipc);
      chk("opcode", bus.OPCODE, m_word[23:20]);
      if (m_valid)
         chk("illegal", bus.InstrIllegal, is_illegal(m_word[23:20]));
   endtask

   task automatic model_step(bit r, bit red, logic [23:0] rpc,
                             bit rdy, bit ack);
      bit fetching;
      fetching = m_started && !m_valid && !m_halted;
      if (r) begin
         model_reset();
      end else if (red) begin
         if (fetching && !ack) begin
            m_kill = 1;
            m_tgt  = rpc;
         end else begin
            m_pc      = rpc;
            m_kill    = 0;
            m_valid   = 0;
            m_halted  = 0;
            m_started = 1;
         end
      end else if (fetching && ack) begin
         if (m_kill) begin
            m_pc   = m_tgt;
            m_kill = 0;
         end else begin
            m_valid = 1;
            m_ipc   = m_pc;
            m_word  = memf(m_pc);
            m_pc    = m_pc + 24'd1;
         end
      end else if (m_valid && rdy) begin
         m_valid  = 0;
         m_halted = (m_word[23:20] == 4'hF);
      end else if (!m_started) begin
         m_started = 1;
      end
   endtask

   initial begin
      int          wait_cnt;
      int          lat;
      bit          r, red, rdy, ack;
      logic [23:0] rpc;

      bus.ImemAck     = 0;
      bus.ImemData    = '0;
      bus.InstrReady  = 0;
      bus.Redirect    = 0;
      bus.RedirectPC  = '0;
      bus2.ImemAck    = 0;
      bus2.ImemData   = '0;
      bus2.InstrReady = 0;
      bus2.Redirect   = 0;
      bus2.RedirectPC = '0;
      model_reset();
      wait_cnt = 0;
      lat      = 0;

      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         check_main();
         r   = (cyc < 3) || ($urandom % 300 == 0);
         red = ($urandom % 8 == 0);
         rpc = ($urandom % 4 == 0) ? 24'hFFFFFE + 24'($urandom % 2)
                                   : 24'($urandom);
         rdy = ($urandom % 4 != 0);
         ack = !r && bus.ImemReq && (wait_cnt >= lat);
         rst            = r;
         bus.Redirect   = red;
         bus.RedirectPC = rpc;
         bus.InstrReady = rdy;
         bus.ImemAck    = ack;
         bus.ImemData   = ack ? memf(bus.ImemAddr) : 24'($urandom);
         if (r || ack) begin
            wait_cnt = 0;
            lat = ($urandom % 2 == 0) ? 0 : $urandom_range(1, 3);
         end else if (bus.ImemReq) begin
            wait_cnt++;
         end
         model_step(r, red, rpc, rdy, ack);
      end

      // wrap from RESET_PC=0xFFFFFF, then reset while draining
      @(negedge clk);
      rst2 = 0;
      @(negedge clk);
      chk("w_req0", bus2.ImemReq, 1);
      chk("w_addr0", bus2.ImemAddr, 24'hFFFFFF);
      bus2.ImemAck    = 1;
      bus2.ImemData   = 24'h100000;
      bus2.InstrReady = 1;
      @(negedge clk);
      chk("w_valid", bus2.InstrValid, 1);
      chk("w_ipc", bus2.InstrPC, 24'hFFFFFF);
      chk("w_op", bus2.OPCODE, 4'h1);
      bus2.ImemAck = 0;
      @(negedge clk);
      chk("w_req1", bus2.ImemReq, 1);
      chk("w_addr1", bus2.ImemAddr, 24'h000000);
      bus2.Redirect   = 1;
      bus2.RedirectPC = 24'h000040;
      @(negedge clk);
      chk("w_drain_req", bus2.ImemReq, 1);
      chk("w_drain_addr", bus2.ImemAddr, 24'h000000);
      bus2.Redirect = 0;
      rst2 = 1;
      @(negedge clk);
      chk("w_rst_req", bus2.ImemReq, 0);
      chk("w_rst_valid", bus2.InstrValid, 0);
      chk("w_rst_instr", bus2.Instr, 0);
      chk("w_rst_ipc", bus2.InstrPC, 0);
      chk("w_rst_op", bus2.OPCODE, 0);
      chk("w_rst_halt", bus2.Halted, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Front end of the 24-bit CPU. Produces the instruction stream that the control unit decodes. It keeps the program counter, fetches 24-bit words from instruction memory over a req/ack handshake, and presents each word with its PC and decoded OPCODE field over a valid/ready interface. It accepts branch/jump redirects from execute and stops fetching on HALT.

Parameters:
ADDR_WIDTH, 24, instruction-memory word-address width
INSTR_WIDTH, 24, instruction width; OPCODE = Instr[INSTR_WIDTH-1 -: 4]
RESET_PC, 0, PC value loaded at reset

Ports:
Clock  in  1  single system clock, rising edge
Reset  in  1  synchronous, active-high
ImemReq  out  1  fetch request, level, held until ImemAck
ImemAddr  out  ADDR_WIDTH  word address of the request
ImemAck  in  1  ImemData valid this cycle; only meaningful while ImemReq=1
ImemData  in  INSTR_WIDTH  fetched word
InstrValid  out  1  Instr/InstrPC/OPCODE valid
InstrReady  in  1  decode accepts the instruction
Instr  out  INSTR_WIDTH  instruction word
InstrPC  out  ADDR_WIDTH  address of Instr
OPCODE  out  4  Instr[23:20], feeds the control unit
InstrIllegal  out  1  OPCODE not in {0001,0010,0011,0100,0110,1111}; qualified by InstrValid
Redirect  in  1  branch/jump taken, one-cycle pulse
RedirectPC  in  ADDR_WIDTH  target for Redirect
Halted  out  1  fetch stopped after a HALT was issued

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- States: IDLE, FETCH, ISSUE, DRAIN, HALT.
- Reset: state=IDLE, PC=RESET_PC, Instr=0, InstrPC=0, InstrValid=0, Halted=0. ImemReq=0 and OPCODE=0 follow from this.
- IDLE: lasts one cycle after Reset deasserts, then goes to FETCH.
- ImemReq=1 only in FETCH and DRAIN. ImemAddr=PC in FETCH and the held address in DRAIN. ImemAddr and ImemReq must not change while a request is waiting for ImemAck.
- FETCH, ImemAck=1: register Instr<=ImemData and InstrPC<=PC. PC<=PC+1, wrapping from 2^ADDR_WIDTH-1 to 0. Go to ISSUE.
- Latency: ack in cycle N gives InstrValid=1 in cycle N+1. Best throughput is one instruction per 2 cycles when memory acks in the same cycle.
- ISSUE: InstrValid=1. Instr, InstrPC and OPCODE stay stable until InstrReady=1.
  - InstrReady=1 and OPCODE=1111: go to HALT.
  - InstrReady=1 and any other opcode: go to FETCH.
- HALT: Halted=1, InstrValid=0, ImemReq=0. Only Redirect or Reset leaves this state.
- InstrIllegal: combinational from OPCODE. An illegal instruction is still issued normally and does not halt fetch.
- Redirect has priority over everything except Reset:
  - FETCH with ImemAck=1 in the same cycle: discard the data, PC<=RedirectPC, stay in FETCH.
  - FETCH with ImemAck=0: latch RedirectPC as the pending PC and go to DRAIN. The request stays up until ack.
  - DRAIN, on ImemAck: discard the data, PC<=pending PC, go to FETCH. A further Redirect in DRAIN overwrites the pending PC (last one wins). Redirect coincident with the draining ack: use the new RedirectPC.
  - ISSUE: InstrValid drops next cycle, PC<=RedirectPC, go to FETCH. If InstrReady=1 in the same cycle, the instruction counts as accepted. A HALT accepted together with a Redirect does not halt.
  - HALT: Halted<=0, PC<=RedirectPC, go to FETCH.
  - IDLE: PC<=RedirectPC, then FETCH.
- Reset mid-operation: any state returns to IDLE next edge, and any outstanding request is abandoned. Instruction memory shares Reset, so no stale ack arrives.
- OPCODE must be 0 whenever Instr=0. No X is ever driven on any output after reset.

Test Plan:
- Reset then straight-line code: memory acks in the same cycle with words 0x100000, 0x212345, 0x34ABCD at addresses 0, 1, 2, InstrReady=1.
  -> ImemReq rises 1 cycle after Reset falls. InstrValid pulses with InstrPC=0, 1, 2 and OPCODE=1, 2, 3, one instruction every 2 cycles.
- Backpressure: hold InstrReady=0 for 5 cycles on word 0x6000AB.
  -> Instr, OPCODE=0110 and InstrPC stay stable. ImemReq=0 throughout. The next fetch address is PC+1.
- Redirect during a slow fetch: ack delayed 3 cycles, Redirect with RedirectPC=0x000040 in the second wait cycle.
  -> ImemAddr stays at the old PC until ack. That data is never issued. The next ImemAddr is 0x000040.
- Redirect coincident with InstrReady in ISSUE (target 0x000010), and Redirect coincident with an ack in FETCH (target 0x000020).
  -> Next ImemAddr is 0x000010 in the first case and 0x000020 in the second. No stale InstrValid in either case.
- HALT and illegal opcodes: issue 0xF00000, then Redirect to 0x000008. Separately issue 0x5xxxxx.
  -> Halted=1 and ImemReq=0 until the Redirect, then fetch resumes at 0x000008. 0x5xxxxx is issued with InstrIllegal=1.
- Wrap and reset: RESET_PC=0xFFFFFF.
  -> Second fetch address is 0x000000. Reset asserted in DRAIN returns all outputs to reset values on the next edge.
